// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of a 16-entry FIFO
// between two REQ/ACK producers. WR/DIN to the FIFO are registered. No write
// is issued while the FIFO is full, or while it is almost full and a write is
// already in flight.
//
// Optional feature: define FIFO_WR_ARBITER_STALLCNT_EN to build the saturating
// stall-cycle counter. Otherwise stall_cnt is tied to zero.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req0/din0   producer 0 request and data (data stable while req high)
//   ack0        one-cycle pulse: din0 has been taken
//   req1/din1   producer 1 request and data
//   ack1        one-cycle pulse: din1 has been taken
//   fifo_wr     FIFO write strobe
//   fifo_din    FIFO write data (holds when fifo_wr is low)
//   fifo_full   FIFO full flag
//   fifo_afull  FIFO almost-full flag (count == 15)
//   fifo_over   FIFO overflow flag
//   gnt_id      producer that owns the current fifo_wr word
//   err         sticky overflow flag
//   stall_cnt   number of cycles spent in STALL (saturating)
module fifo_wr_arbiter #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] din0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] din1,
    output logic          ack1,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_din,
    input  logic          fifo_full,
    input  logic          fifo_afull,
    input  logic          fifo_over,
    output logic          gnt_id,
    output logic          err,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      ack_reg, ack_next;
    logic [DW-1:0]   din_reg, din_next;
    logic            gnt_reg, gnt_next;
    logic            last_reg, last_next;
    logic            err_reg;

    logic [1:0]      req_vec;
    logic [1:0]      elig;
    logic [DW-1:0]   din_vec [2];
    logic            wr_allowed;
    logic            win;

    assign req_vec    = {req1, req0};
    assign din_vec[0] = din0;
    assign din_vec[1] = din1;

    // A requester whose ACK is high this cycle already had its word taken;
    // masking it keeps the same word from being written twice.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = req_vec[gi] & ~ack_reg[gi];
        end
    endgenerate

    // Being in WRITE means a word lands in the FIFO at the next edge, so
    // almost-full is as good as full in that case.
    assign wr_allowed = ~fifo_full & ~((state_reg == WRITE) & fifo_afull);

    // On a tie the producer that did not win last time gets the grant.
    assign win = (&elig) ? ~last_reg : elig[1];

    always_comb begin
        state_next = IDLE;
        ack_next   = 2'b00;
        din_next   = din_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        if (wr_allowed && (|elig)) begin
            state_next    = WRITE;
            ack_next[win] = 1'b1;
            din_next      = din_vec[win];
            gnt_next      = win;
            last_next     = win;
        end else if (|elig) begin
            state_next = STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ack_reg   <= 2'b00;
            din_reg   <= '0;
            gnt_reg   <= 1'b0;
            last_reg  <= 1'b1;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            din_reg   <= din_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
            err_reg   <= err_reg | fifo_over;
        end
    end

`ifdef FIFO_WR_ARBITER_STALLCNT_EN
    logic [CW-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == STALL) && (stall_cnt_reg != {CW{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = '0;
`endif

    assign fifo_wr  = (state_reg == WRITE);
    assign fifo_din = din_reg;
    assign ack0     = ack_reg[0];
    assign ack1     = ack_reg[1];
    assign gnt_id   = gnt_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a behavioural 16-entry FIFO and two
// randomised producers surround the arbiter; a per-cycle reference model
// and a per-producer ordering scoreboard check every output.
module tb_fifo_wr_arbiter;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, ack0, ack1;
    logic [DW-1:0] din0, din1;
    logic          fifo_wr, fifo_full, fifo_afull, fifo_over;
    logic [DW-1:0] fifo_din;
    logic          gnt_id, err;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .din0(din0), .ack0(ack0),
        .req1(req1), .din1(din1), .ack1(ack1),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .fifo_full(fifo_full), .fifo_afull(fifo_afull), .fifo_over(fifo_over),
        .gnt_id(gnt_id), .err(err), .stall_cnt(stall_cnt)
    );

    // ---------------- behavioural FIFO ----------------
    logic [DW-1:0] fmem [16];
    int            fcount, frp, fwp;
    logic          fover;
    logic          fifo_rd;

    always @(posedge clk) begin
        if (rst) begin
            fcount <= 0; frp <= 0; fwp <= 0; fover <= 1'b0;
        end else begin
            fover <= fifo_wr && (fcount == 16);
            if (fifo_wr && fcount < 16) begin
                fmem[fwp] <= fifo_din;
                fwp <= (fwp + 1) % 16;
            end
            if (fifo_rd && fcount > 0) frp <= (frp + 1) % 16;
            fcount <= fcount + ((fifo_wr && fcount < 16) ? 1 : 0)
                             - ((fifo_rd && fcount > 0) ? 1 : 0);
        end
    end
    assign fifo_full  = (fcount == 16);
    assign fifo_afull = (fcount == 15);
    assign fifo_over  = fover;

    // ---------------- producers ----------------
    logic          preq [2];
    logic [DW-1:0] pdin [2];
    logic [DW-1:0] base [2];
    int            total [2];
    int            sent [2];
    int            wr_seen [2];
    int            hold_pct, rd_pct;
    bit            rd_once, rst_req, capt_first;
    int            first_gnt, stall_edges;

    assign req0 = preq[0];
    assign req1 = preq[1];
    assign din0 = pdin[0];
    assign din1 = pdin[1];

    function automatic logic [DW-1:0] prod_word(int i, int n);
        logic [DW-1:0] nn;
        nn = n[DW-1:0];
        return base[i] + nn;
    endfunction

    // ---------------- reference model state ----------------
    logic          m_wr, m_gnt, m_last, m_stall, m_err;
    logic [1:0]    m_ack;
    logic [DW-1:0] m_din;
    int            m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_din = '0; m_ack = 2'b00; m_gnt = 0;
        m_last = 1; m_stall = 0; m_err = 0; m_cnt = 0;
    endtask

    // Next-cycle expectation from the rules: eligible = requesting and not
    // currently acked; write allowed unless full or (writing and almost full).
    task automatic model_next();
        logic [1:0] pend;
        logic allowed;
        int w;
        for (int i = 0; i < 2; i++) pend[i] = preq[i] && !m_ack[i];
        allowed = (fcount != 16) && !(m_wr && fcount == 15);
        if (rst) begin
            model_reset();
            stall_edges = 0;
        end else begin
            m_err = m_err | fover;
            if (m_stall) stall_edges++;
`ifdef FIFO_WR_ARBITER_STALLCNT_EN
            if (m_stall && m_cnt < CMAX) m_cnt++;
`else
            m_cnt = 0;
`endif
            if (allowed && pend != 2'b00) begin
                if (pend == 2'b11) w = 1 - int'(m_last);
                else w = pend[0] ? 0 : 1;
                m_wr = 1; m_din = pdin[w]; m_ack = 2'b00; m_ack[w] = 1'b1;
                m_gnt = w[0]; m_last = w[0]; m_stall = 0;
            end else begin
                m_wr = 0; m_ack = 2'b00; m_stall = (pend != 2'b00);
            end
        end
    endtask

    // One clock cycle: compare at the negedge, react as producers/FIFO
    // reader, then compute what the next edge should produce.
    task automatic cycle();
        int g;
        @(negedge clk);
        check("fifo_wr", fifo_wr, m_wr);
        check("fifo_din", fifo_din, m_din);
        check("ack0", ack0, m_ack[0]);
        check("ack1", ack1, m_ack[1]);
        check("gnt_id", gnt_id, m_gnt);
        check("err", err, m_err);
        check("stall_cnt", stall_cnt, m_cnt);
        if (fifo_wr === 1'b1) begin
            g = (gnt_id === 1'b1) ? 1 : 0;
            check("order", fifo_din, prod_word(g, wr_seen[g]));
            $display("wr id=%0d din=%h fifo_count=%0d", g, fifo_din, fcount);
            wr_seen[g]++;
            if (capt_first) begin
                first_gnt = g;
                capt_first = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (preq[i] && ((i == 0) ? ack0 : ack1)) begin
                sent[i]++;
                preq[i] = (sent[i] < total[i]) && ($urandom_range(99) < hold_pct);
            end else if (!preq[i] && sent[i] < total[i] && $urandom_range(99) < hold_pct) begin
                preq[i] = 1'b1;
            end
            pdin[i] = prod_word(i, sent[i]);
        end
        fifo_rd = rd_once || ($urandom_range(99) < rd_pct);
        rd_once = 0;
        rst = rst_req;
        model_next();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic start_scn(logic [DW-1:0] b0, int t0, logic [DW-1:0] b1, int t1, int hp, int rp);
        total[0] = 0; total[1] = 0;
        preq[0] = 0; preq[1] = 0;
        rd_pct = 0;
        rst_req = 1;
        run(2);
        for (int i = 0; i < 2; i++) begin
            sent[i] = 0; wr_seen[i] = 0;
        end
        base[0] = b0; base[1] = b1; total[0] = t0; total[1] = t1;
        hold_pct = hp; rd_pct = rp;
        first_gnt = 2; capt_first = 1;
        rst_req = 0;
    endtask

    int exp_stall;

    initial begin
        rst = 1; rst_req = 1; fifo_rd = 0; rd_once = 0;
        hold_pct = 100; rd_pct = 0; capt_first = 0; first_gnt = 2; stall_edges = 0;
        for (int i = 0; i < 2; i++) begin
            preq[i] = 0; pdin[i] = '0; base[i] = '0; total[i] = 0; sent[i] = 0; wr_seen[i] = 0;
        end
        model_reset();
        @(posedge clk);

        // 1: single request after reset
        start_scn(16'h0005, 1, 16'h0000, 0, 100, 0);
        run(5);
        check("s1_count", fcount, 1);
        check("s1_data", fmem[frp], 16'h0005);
        check("s1_first", first_gnt, 0);

        // 2: both requesting continuously, FIFO drained every cycle
        start_scn(16'hA000, 24, 16'hB000, 24, 100, 100);
        run(60);
        check("s2_first", first_gnt, 0);
        check("s2_w0", wr_seen[0], 24);
        check("s2_w1", wr_seen[1], 24);

        // 3: fill with no reads
        start_scn(16'h3000, 20, 16'h0000, 0, 100, 0);
        run(50);
        check("s3_writes", wr_seen[0], 16);
        check("s3_acked", sent[0], 16);
        check("s3_count", fcount, 16);
        check("s3_wr_low", fifo_wr, 1'b0);
        check("s3_over", fifo_over, 1'b0);
        check("s3_err", err, 1'b0);

        // 4: one read frees a slot -> exactly one more grant with word 17
        rd_once = 1;
        run(8);
        check("s4_writes", wr_seen[0], 17);
        check("s4_count", fcount, 16);
        check("s4_data", fmem[(fwp + 15) % 16], 16'h3010);
        check("s4_err", err, 1'b0);

        // 5: producer 1 stalled against a full FIFO
        start_scn(16'h0000, 0, 16'h5000, 30, 100, 0);
        run(60);
        check("s5_full", fcount, 16);
`ifdef FIFO_WR_ARBITER_STALLCNT_EN
        exp_stall = (stall_edges > CMAX) ? CMAX : stall_edges;
`else
        exp_stall = 0;
`endif
        check("s5_stall_cnt", stall_cnt, exp_stall);

        // 6: reset in the middle of random traffic, then both request
        start_scn(16'h6000, 400, 16'h7000, 400, 70, 60);
        run(25);
        hold_pct = 100;
        rst_req = 1;
        run(1);
        rst_req = 0;
        preq[0] = 1; preq[1] = 1;
        first_gnt = 2; capt_first = 1;
        run(4);
        check("s6_first", first_gnt, 0);
        hold_pct = 60; rd_pct = 50;
        run(300);
        check("s6_acks0", sent[0], wr_seen[0]);
        check("s6_acks1", sent[1], wr_seen[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of the 16-bit, 16-entry `fifo` block between two producers. Each producer uses a REQ/ACK handshake. The arbiter issues registered `WR`/`DIN` to the FIFO and never writes while the FIFO is full or about to become full. It sits directly in front of `fifo`; the FIFO read side is untouched.

## Interface
Parameters:
- `DW`, 16, data width; must equal the FIFO `DIN` width.
- `CW`, 8, width of the stall counter.

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST` in 1: synchronous, active-high reset.
- `REQ0` in 1: producer 0 has a word; held until `ACK0`.
- `DIN0` in DW: producer 0 data; stable while `REQ0` is high.
- `ACK0` out 1: one-cycle pulse; the word on `DIN0` has been taken.
- `REQ1`, `DIN1`, `ACK1`: same as above, for producer 1.
- `FIFO_WR` out 1: drives FIFO `WR`.
- `FIFO_DIN` out DW: drives FIFO `DIN`.
- `FIFO_FULL` in 1: from FIFO `FULL`.
- `FIFO_AFULL` in 1: from FIFO `almostFULL` (count == 15).
- `FIFO_OVER` in 1: from FIFO `OVER`.
- `GNT_ID` out 1: producer of the current `FIFO_WR` word.
- `ERR` out 1: sticky flag; set on any `FIFO_OVER`.
- `STALL_CNT` out CW: cycles spent in STALL (see Configuration).

## Operation
- **State machine** (registered): IDLE, WRITE, STALL.
  - IDLE: no write issued and no eligible request.
  - WRITE: `FIFO_WR` is high this cycle.
  - STALL: at least one eligible request is pending but blocked by fullness.
- **Eligible request:** `REQx`=1 and `ACKx`=0. A requester whose ACK is high this cycle is masked, so a word is never taken twice.
- **Write allowed** when `FIFO_FULL`=0 and not (`FIFO_WR`=1 and `FIFO_AFULL`=1). This accounts for the in-flight write.
- **Grant.** If write is allowed and at least one request is eligible, at the next edge:
  - `FIFO_WR`<=1, `FIFO_DIN`<=`DINx`, `ACKx`<=1, `GNT_ID`<=x.
  - Next state WRITE.
  - Otherwise `FIFO_WR`<=0 and all ACKs <=0. Next state is STALL if any request is eligible, else IDLE.
- **Round robin.** Register `LAST` holds the last granted id.
  - When both requests are eligible, the one ≠ `LAST` wins.
  - `LAST` updates only on a grant.
- **Throughput.** A single producer gets at most one word per 2 cycles. Two producers alternating get one word per cycle.
- `FIFO_DIN` holds its last value when `FIFO_WR`=0.
- `ERR` is set on the edge after `FIFO_OVER`=1 and is cleared only by `RST`.

## Timing
- **Reset values:** `FIFO_WR`=0, `FIFO_DIN`=0, `ACK0`=`ACK1`=0, `GNT_ID`=0, `ERR`=0, `STALL_CNT`=0, state IDLE, `LAST`=1 (producer 0 wins the first tie).
- **Latency.** `REQx` sampled high at edge k gives `FIFO_WR`/`ACKx` high for cycle k..k+1. The FIFO captures the word at edge k+1. The producer may drop REQ or present the next word at edge k+1.
- **Full.**
  - `FIFO_FULL`=1 at edge k: no grant; the request waits with no data lost.
  - `FIFO_AFULL`=1 with `FIFO_WR`=1: no grant at that edge, so a 16th write is followed by a bubble. This ensures no overflow.
- **Read freeing space.** A simultaneous FIFO read is ignored by the arbiter. The next grant happens the edge after `FIFO_FULL` falls.
- **Reset mid-operation.** `RST` wins over everything. A word whose ACK was already pulsed is delivered. A pending un-ACKed request is re-arbitrated after reset.
- **Request withdrawal.** `REQx` dropping without ACK is a protocol violation; the arbiter simply does not grant it.

## Configuration
- **Macro `FIFO_WR_ARBITER_STALLCNT_EN`.**
- **Defined:** `STALL_CNT` increments by 1 on each edge where the current state is STALL. It saturates at 2^CW−1 and is reset by `RST`.
- **Undefined:** the counter logic is removed and `STALL_CNT` is tied to 0. The port list is unchanged.

## Test plan
1. **Single request after reset.** `RST` for 1 cycle, then `REQ0`=1, `DIN0`=16'h0005 for 1 cycle → `FIFO_WR`=1, `FIFO_DIN`=16'h0005, `ACK0`=1, `GNT_ID`=0 on the next cycle. FIFO reads back 16'h0005.
2. **Both requesting continuously.** `DIN0`=16'hA000+n, `DIN1`=16'hB000+n → writes alternate 0,1,0,1 starting with 0, one per cycle. Each producer's words arrive in order.
3. **Fill with no reads.** `REQ0` held with 20 words, FIFO empty at start → exactly 16 writes, then `FIFO_WR`=0 with `FIFO_FULL`=1. `OVER` and `ERR` stay 0. Pending words remain unACKed.
4. **Drain after full.** From scenario 3, pulse FIFO `RD` for 1 cycle → one further grant the edge after `FIFO_FULL` falls, with the correct 17th word.
5. **Stall counter.** With the macro defined, hold the FIFO full with `REQ1`=1 for 10 cycles → `STALL_CNT`=10. With the macro undefined → `STALL_CNT`=0.
6. **Reset during a write burst.** Assert `RST` during a burst → all outputs return to reset values on the next edge. The first grant after reset goes to producer 0 when both request.
